// File: rtl/pcap_frame_core.sv
// pcap_frame_core: multi-channel position capture with per-channel mode
// (value / difference / gated sum), channel mask and a ready/valid word
// stream toward the DMA writer.
// Optional feature: define PCAP_TIMESTAMP_EN to prefix every frame with a
// 32-bit RUN-cycle timestamp word.

// Per-channel datapath: gated-sum accumulator, difference reference and
// the snapshot word captured for the emitter.
module pcap_chan #(
  parameter int SUMW = 64
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        i_clr,
  input  logic        i_load_prev,
  input  logic        i_run,
  input  logic        i_gate,
  input  logic        i_cap,
  input  logic [1:0]  i_mode,
  input  logic [5:0]  i_shift,
  input  logic [31:0] i_pos,
  output logic [31:0] o_snap
);
  logic [SUMW-1:0] r_acc;
  logic [31:0]     r_prev;
  logic [31:0]     r_snap;
  logic [SUMW-1:0] w_smp;
  logic [SUMW-1:0] w_gs;
  logic [31:0]     w_shlo;

  assign w_smp  = {{(SUMW-32){i_pos[31]}}, i_pos};
  assign w_gs   = i_gate ? w_smp : '0;
  // Arithmetic shift of the running sum; only the low word is reported.
  assign w_shlo = 32'($signed(r_acc) >>> i_shift);
  assign o_snap = r_snap;

  // Accumulate while running; on capture load the snapshot by mode.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_acc  <= '0;
      r_prev <= '0;
      r_snap <= '0;
    end else if (i_clr) begin
      r_acc  <= '0;
      r_prev <= '0;
      r_snap <= '0;
    end else begin
      if (i_load_prev) r_prev <= i_pos;
      if (i_run) begin
        // A sum capture reports the total up to last cycle and restarts
        // the accumulator with this cycle's gated sample.
        if (i_cap && i_mode == 2'd2) r_acc <= w_gs;
        else                         r_acc <= r_acc + w_gs;
      end
      if (i_cap) begin
        case (i_mode)
          2'd1: begin
            r_snap <= i_pos - r_prev;
            r_prev <= i_pos;
          end
          2'd2:    r_snap <= w_shlo;
          default: r_snap <= i_pos;
        endcase
      end
    end
  end
endmodule

module pcap_frame_core #(
  parameter int NCH  = 8,
  parameter int SUMW = 64
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              ARM,
  input  logic              DISARM,
  input  logic [1:0]        CAPTURE_EDGE,
  input  logic [5:0]        SHIFT_SUM,
  input  logic [NCH-1:0]    CH_MASK,
  input  logic [2*NCH-1:0]  CH_MODE,
  input  logic              enable_i,
  input  logic              gate_i,
  input  logic              capture_i,
  input  logic [32*NCH-1:0] posbus_i,
  input  logic              dat_ready_i,
  output logic [31:0]       dat_o,
  output logic              dat_valid_o,
  output logic              done_o,
  output logic              actv_o,
  output logic [1:0]        HEALTH
);
  localparam int IW = $clog2(NCH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DRAIN} state_t;

  state_t                  r_state, w_nstate;
  logic                    r_cap_q, r_en_q;
  logic                    r_pend;
  logic [IW-1:0]           r_idx;
  logic [31:0]             r_dat;
  logic                    r_vld;
  logic                    r_done;
  logic [1:0]              r_health;
  logic [NCH-1:0][31:0]    w_snap;

  logic w_rise, w_fall, w_cap_edge;
  logic w_en_rise, w_en_fall;
  logic w_in_run, w_cap_hit, w_cap_ok, w_ovr;
  logic w_slot, w_fin, w_clr, w_load_prev, w_live;
  logic w_hit, w_more;
  logic [IW-1:0] w_nxt;
  logic [31:0]   w_word;

`ifdef PCAP_TIMESTAMP_EN
  logic [31:0] r_ts, r_ts_snap;
  logic        r_tsp;
`endif

  assign w_rise    = capture_i & ~r_cap_q;
  assign w_fall    = ~capture_i & r_cap_q;
  assign w_cap_edge = (CAPTURE_EDGE[0] & w_rise) | (CAPTURE_EDGE[1] & w_fall);
  assign w_en_rise = enable_i & ~r_en_q;
  assign w_en_fall = ~enable_i & r_en_q;

  assign w_in_run  = (r_state == S_RUN);
  assign w_live    = (r_state == S_ARMED) || (r_state == S_RUN);
  // DISARM beats a coincident capture; a capture while a frame is still
  // being read out of the snapshot is an overrun and is discarded.
  assign w_cap_hit = w_in_run & w_cap_edge & ~DISARM;
  assign w_cap_ok  = w_cap_hit & ~r_pend;
  assign w_ovr     = w_cap_hit & r_pend;

  assign w_slot      = ~r_vld | dat_ready_i;
  assign w_fin       = ~r_pend & w_slot;
  assign w_clr       = (r_state == S_IDLE) & ARM;
  assign w_load_prev = (r_state == S_ARMED) & w_en_rise;

  assign dat_o       = r_dat;
  assign dat_valid_o = r_vld;
  assign done_o      = r_done;
  assign HEALTH      = r_health;

  // Per-channel datapaths.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    pcap_chan #(.SUMW(SUMW)) u_ch (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .i_clr       (w_clr),
      .i_load_prev (w_load_prev),
      .i_run       (w_in_run),
      .i_gate      (gate_i),
      .i_cap       (w_cap_ok),
      .i_mode      (CH_MODE[2*k +: 2]),
      .i_shift     (SHIFT_SUM),
      .i_pos       (posbus_i[32*k +: 32]),
      .o_snap      (w_snap[k])
    );
  end

  // Input history for edge detection of capture and enable.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cap_q <= 1'b0;
      r_en_q  <= 1'b0;
    end else begin
      r_cap_q <= capture_i;
      r_en_q  <= enable_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_nstate;
  end

  // FSM next-state logic.
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  if (ARM) w_nstate = S_ARMED;
      S_ARMED: begin
        if (DISARM || w_en_fall) w_nstate = S_DRAIN;
        else if (w_en_rise)      w_nstate = S_RUN;
      end
      S_RUN:   if (DISARM || w_en_fall || w_ovr) w_nstate = S_DRAIN;
      S_DRAIN: if (w_fin) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    actv_o = (r_state != S_IDLE);
  end

  // Health: cleared by ARM, DISARM takes precedence over overrun.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)             r_health <= 2'd0;
    else if (w_clr)             r_health <= 2'd0;
    else if (w_live && DISARM)  r_health <= 2'd2;
    else if (w_ovr)             r_health <= 2'd1;
  end

  // End-of-acquisition pulse once the drain has nothing left to send.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_done <= 1'b0;
    else            r_done <= (r_state == S_DRAIN) && w_fin;
  end

  // Find the lowest masked channel at or above the read pointer and
  // whether another one follows it.
  always_comb begin
    w_hit  = 1'b0;
    w_more = 1'b0;
    w_nxt  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (CH_MASK[k] && (IW'(k) >= r_idx)) begin
        if (w_hit) w_more = 1'b1;
        else begin
          w_hit = 1'b1;
          w_nxt = IW'(k);
        end
      end
    end
  end

  // Snapshot word of the selected channel.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < NCH; k++)
      if (IW'(k) == w_nxt) w_word = w_snap[k];
  end

  // Emitter: loads the output register whenever it is free and a frame
  // is pending; r_pend drops as the last word is loaded, which frees the
  // snapshot for the next capture.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_dat  <= '0;
      r_vld  <= 1'b0;
      r_pend <= 1'b0;
      r_idx  <= '0;
`ifdef PCAP_TIMESTAMP_EN
      r_tsp  <= 1'b0;
`endif
    end else begin
      if (w_slot) begin
        if (r_pend) begin
`ifdef PCAP_TIMESTAMP_EN
          if (r_tsp) begin
            r_dat  <= r_ts_snap;
            r_vld  <= 1'b1;
            r_tsp  <= 1'b0;
            r_pend <= w_hit;
          end else
`endif
          if (w_hit) begin
            r_dat  <= w_word;
            r_vld  <= 1'b1;
            r_idx  <= w_nxt + IW'(1);
            r_pend <= w_more;
          end else begin
            r_vld  <= 1'b0;
            r_pend <= 1'b0;
          end
        end else begin
          r_vld <= 1'b0;
        end
      end
      if (w_cap_ok) begin
        r_idx  <= '0;
`ifdef PCAP_TIMESTAMP_EN
        r_pend <= 1'b1;
        r_tsp  <= 1'b1;
`else
        r_pend <= |CH_MASK;
`endif
      end
    end
  end

`ifdef PCAP_TIMESTAMP_EN
  // RUN-cycle counter, cleared on entry to RUN and latched per capture.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ts      <= '0;
      r_ts_snap <= '0;
    end else begin
      if (r_state == S_ARMED && w_nstate == S_RUN) r_ts <= '0;
      else if (w_in_run)                           r_ts <= r_ts + 32'd1;
      if (w_cap_ok) r_ts_snap <= r_ts;
    end
  end
`endif

endmodule
